// File: rtl/fpu_pkg.sv
// Shared constants and stage records for the single-precision add back end.
package fpu_pkg;

    localparam int EXP_BIAS   = 127;
    localparam int EXP_MAX    = 255;

    // Bit positions inside the 56-bit unnormalized sum.
    localparam int CARRY_BIT  = 55;
    localparam int HIDDEN_BIT = 54;
    localparam int GUARD_BIT  = 30;
    localparam int ROUND_BIT  = 29;

    localparam logic [31:0] FP_INF  = 32'h7F80_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    // Stage 1: raw adder result as captured.
    typedef struct packed {
        logic        sign;
        logic [55:0] sum;
        logic [7:0]  exp;
    } cap_t;

    // Stage 2: normalized magnitude aligned so bit 54 is the hidden bit,
    // plus the two special-case markers that bypass rounding.
    typedef struct packed {
        logic               sign;
        logic [54:0]        mant;
        logic signed [9:0]  exp;
        logic               zero;
        logic               inf;
    } norm_t;

endpackage

// File: rtl/fpu_lzc55.sv
// Combinational leading-zero counter over 55 bits; all-zero input gives 55.
module fpu_lzc55 (
    input  logic [54:0] din,
    output logic [5:0]  count
);

    // Scan upward so the most significant set bit is the last one to win.
    always_comb begin
        count = 6'd55;
        for (int i = 0; i < 55; i++) begin
            if (din[i]) count = 6'(54 - i);
        end
    end

endmodule

// File: rtl/fpu_normalize_round.sv
// Normalize / round-to-nearest-even / pack stage of the binary32 add path.
// Three registered stages: capture, normalize, round+pack.
module fpu_normalize_round
    import fpu_pkg::*;
#(
    parameter int MANT_W = 23,
    parameter int EXP_W  = 8,
    parameter int SUM_W  = 56
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              sign,
    input  logic [SUM_W-1:0]  sum_2,
    input  logic [EXP_W-1:0]  exponent_2,
    output logic [31:0]       out,
    output logic              out_valid,
    output logic              overflow,
    output logic              underflow,
    output logic              inexact
);

    logic        v1_q, v1_d, v2_q, v2_d;
    cap_t        s1_q, s1_d;
    norm_t       s2_q, s2_d;
    logic [31:0] out_q, out_d;
    logic        out_valid_q, out_valid_d;
    logic        ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

    // Stage 1: capture the adder result while enable is high.
    always_comb begin
        v1_d = enable;
        s1_d = s1_q;
        if (enable) begin
            s1_d.sign = sign;
            s1_d.sum  = sum_2;
            s1_d.exp  = exponent_2;
        end
    end

    logic [5:0]        lzc;
    logic signed [9:0] e_in, e_lim, lzc_s, shamt;

    fpu_lzc55 u_lzc (
        .din   (s1_q.sum[HIDDEN_BIT:0]),
        .count (lzc)
    );

    // Stage 2: normalize. The left shift is clamped so the exponent never
    // drops below 1; whatever shift remains unused leaves a denormal.
    always_comb begin
        v2_d  = v1_q;
        s2_d  = s2_q;
        e_in  = (s1_q.exp == '0) ? 10'sd1 : $signed({2'b00, s1_q.exp});
        e_lim = e_in - 10'sd1;
        lzc_s = $signed({4'b0000, lzc});
        shamt = (lzc_s > e_lim) ? e_lim : lzc_s;
        if (v1_q) begin
            s2_d.sign = s1_q.sign;
            // Infinity input takes priority over a zero magnitude.
            s2_d.inf  = (s1_q.exp == 8'(EXP_MAX));
            s2_d.zero = (s1_q.sum == '0);
            if (s1_q.sum[CARRY_BIT]) begin
                // Bit shifted off the bottom folds into sticky.
                s2_d.mant = {s1_q.sum[55:2], s1_q.sum[1] | s1_q.sum[0]};
                s2_d.exp  = e_in + 10'sd1;
            end else begin
                s2_d.mant = s1_q.sum[HIDDEN_BIT:0] << shamt[5:0];
                s2_d.exp  = e_in - shamt;
            end
        end
    end

    logic                lsb, g, r, s, rup, hid, inx;
    logic [24:0]         mant_r;
    logic signed [9:0]   e_r;
    logic [MANT_W-1:0]   frac;
    logic [7:0]          field;

    // Stage 3: RNE rounding, overflow detection and final packing.
    // Outputs only move when a valid result arrives.
    always_comb begin
        out_d       = out_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        inx_d       = inx_q;
        out_valid_d = v2_q;
        lsb    = s2_q.mant[GUARD_BIT+1];
        g      = s2_q.mant[GUARD_BIT];
        r      = s2_q.mant[ROUND_BIT];
        s      = |s2_q.mant[ROUND_BIT-1:0];
        rup    = g & (r | s | lsb);
        inx    = g | r | s;
        mant_r = {1'b0, s2_q.mant[HIDDEN_BIT:GUARD_BIT+1]} + 25'(rup);
        if (mant_r[24]) begin
            e_r  = s2_q.exp + 10'sd1;
            frac = '0;
            hid  = 1'b1;
        end else begin
            e_r  = s2_q.exp;
            frac = mant_r[MANT_W-1:0];
            hid  = mant_r[23];
        end
        // Denormals sit at exponent 1; hidden bit clear means field 0, and a
        // denormal that rounds into the hidden bit naturally gets field 1.
        field  = hid ? e_r[7:0] : 8'h00;
        if (v2_q) begin
            if (s2_q.inf) begin
                out_d = {s2_q.sign, FP_INF[30:0]};
                ovf_d = 1'b0;
                unf_d = 1'b0;
                inx_d = 1'b0;
            end else if (s2_q.zero) begin
                out_d = 32'h0000_0000;
                ovf_d = 1'b0;
                unf_d = 1'b0;
                inx_d = 1'b0;
            end else if (e_r >= 10'sd255) begin
                out_d = {s2_q.sign, FP_INF[30:0]};
                ovf_d = 1'b1;
                unf_d = 1'b0;
                inx_d = 1'b1;
            end else begin
                out_d = {s2_q.sign, field, frac};
                ovf_d = 1'b0;
                unf_d = (field == 8'h00) & inx;
                inx_d = inx;
            end
        end
    end

    // All pipeline state, cleared asynchronously so in-flight work is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            s1_q        <= '0;
            s2_q        <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inx_q       <= 1'b0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inx_q       <= inx_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;
    assign inexact   = inx_q;

endmodule

// File: tb/tb_fpu_normalize_round.sv
// Directed bench for fpu_normalize_round: latency, normalization, RNE,
// overflow/denormal/special packing, streaming and mid-flight reset.
module tb_fpu_normalize_round;

    logic        clk, rst, enable, sign;
    logic [55:0] sum_2;
    logic [7:0]  exponent_2;
    logic [31:0] out;
    logic        out_valid, overflow, underflow, inexact;

    int tests, fails;

    // flags f = {overflow, underflow, inexact}
    typedef struct packed {
        logic        s;
        logic [55:0] sum;
        logic [7:0]  ex;
        logic [31:0] o;
        logic [2:0]  f;
    } vec_t;

    fpu_normalize_round dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .sign       (sign),
        .sum_2      (sum_2),
        .exponent_2 (exponent_2),
        .out        (out),
        .out_valid  (out_valid),
        .overflow   (overflow),
        .underflow  (underflow),
        .inexact    (inexact)
    );

    always #5 clk = ~clk;

    // One-cycle enable pulse, then count rising edges until out_valid (bounded).
    task automatic send(input logic s, input logic [55:0] sm, input logic [7:0] ex,
                        output int lat);
        @(negedge clk);
        enable = 1'b1; sign = s; sum_2 = sm; exponent_2 = ex;
        @(negedge clk);
        enable = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({out_valid, out, overflow, underflow, inexact} !== 36'd0) begin
            fails++;
            $display("FAIL reset: valid=%b out=%h flags=%b%b%b, want all 0",
                     out_valid, out, overflow, underflow, inexact);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_basic();
        vec_t v[2] = '{
            '{1'b0, 56'h40_0000_0000_0000, 8'd127, 32'h3F80_0000, 3'b000},
            '{1'b0, 56'h40_0000_0000_0000, 8'd0,   32'h0080_0000, 3'b000}};
        int lat;
        foreach (v[i]) begin
            send(v[i].s, v[i].sum, v[i].ex, lat);
            tests++;
            if (lat != 3 || {out, overflow, underflow, inexact} !== {v[i].o, v[i].f}) begin
                fails++;
                $display("FAIL basic[%0d]: lat=%0d out=%h flags=%b%b%b, want lat=3 out=%h flags=%b",
                         i, lat, out, overflow, underflow, inexact, v[i].o, v[i].f);
            end
        end
    endtask

    task automatic test_carry();
        vec_t v[2] = '{
            '{1'b0, 56'h80_0000_0000_0000, 8'd127, 32'h4000_0000, 3'b000},
            '{1'b0, 56'h80_0000_0000_0001, 8'd127, 32'h4000_0000, 3'b001}};
        int lat;
        foreach (v[i]) begin
            send(v[i].s, v[i].sum, v[i].ex, lat);
            tests++;
            if (lat != 3 || {out, overflow, underflow, inexact} !== {v[i].o, v[i].f}) begin
                fails++;
                $display("FAIL carry[%0d]: lat=%0d out=%h flags=%b%b%b, want lat=3 out=%h flags=%b",
                         i, lat, out, overflow, underflow, inexact, v[i].o, v[i].f);
            end
        end
    endtask

    task automatic test_lzc();
        vec_t v[2] = '{
            '{1'b0, 56'h04_0000_0000_0000, 8'd127, 32'h3D80_0000, 3'b000},
            '{1'b0, 56'h04_0000_0000_0000, 8'd2,   32'h0010_0000, 3'b000}};
        int lat;
        foreach (v[i]) begin
            send(v[i].s, v[i].sum, v[i].ex, lat);
            tests++;
            if (lat != 3 || {out, overflow, underflow, inexact} !== {v[i].o, v[i].f}) begin
                fails++;
                $display("FAIL lzc[%0d]: lat=%0d out=%h flags=%b%b%b, want lat=3 out=%h flags=%b",
                         i, lat, out, overflow, underflow, inexact, v[i].o, v[i].f);
            end
        end
    endtask

    task automatic test_rne();
        vec_t v[5] = '{
            '{1'b0, 56'h40_0000_4000_0000, 8'd127, 32'h3F80_0000, 3'b001},
            '{1'b0, 56'h40_0000_C000_0000, 8'd127, 32'h3F80_0002, 3'b001},
            '{1'b0, 56'h40_0000_6000_0000, 8'd127, 32'h3F80_0001, 3'b001},
            '{1'b0, 56'h3F_FFFF_C000_0000, 8'd1,   32'h0080_0000, 3'b001},
            '{1'b0, 56'h00_0000_A000_0000, 8'd1,   32'h0000_0001, 3'b011}};
        int lat;
        foreach (v[i]) begin
            send(v[i].s, v[i].sum, v[i].ex, lat);
            tests++;
            if (lat != 3 || {out, overflow, underflow, inexact} !== {v[i].o, v[i].f}) begin
                fails++;
                $display("FAIL rne[%0d]: lat=%0d out=%h flags=%b%b%b, want lat=3 out=%h flags=%b",
                         i, lat, out, overflow, underflow, inexact, v[i].o, v[i].f);
            end
        end
    endtask

    task automatic test_overflow_special();
        vec_t v[4] = '{
            '{1'b1, 56'h80_0000_0000_0000, 8'd254, 32'hFF80_0000, 3'b101},
            '{1'b0, 56'h7F_FFFF_C000_0000, 8'd254, 32'h7F80_0000, 3'b101},
            '{1'b1, 56'h00_0000_0000_0000, 8'd127, 32'h0000_0000, 3'b000},
            '{1'b1, 56'h40_0000_0000_0000, 8'd255, 32'hFF80_0000, 3'b000}};
        int lat;
        foreach (v[i]) begin
            send(v[i].s, v[i].sum, v[i].ex, lat);
            tests++;
            if (lat != 3 || {out, overflow, underflow, inexact} !== {v[i].o, v[i].f}) begin
                fails++;
                $display("FAIL ovf_special[%0d]: lat=%0d out=%h flags=%b%b%b, want lat=3 out=%h flags=%b",
                         i, lat, out, overflow, underflow, inexact, v[i].o, v[i].f);
            end
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[4] = '{
            '{1'b0, 56'h40_0000_0000_0000, 8'd127, 32'h3F80_0000, 3'b000},
            '{1'b0, 56'h80_0000_0000_0000, 8'd127, 32'h4000_0000, 3'b000},
            '{1'b0, 56'h04_0000_0000_0000, 8'd127, 32'h3D80_0000, 3'b000},
            '{1'b1, 56'h40_0000_C000_0000, 8'd127, 32'hBF80_0002, 3'b001}};
        logic        ev;
        logic [34:0] eo;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            ev = (i >= 3 && i < 7);
            eo = ev ? {v[i-3].o, v[i-3].f} : 35'd0;
            tests++;
            if (out_valid !== ev || (ev && {out, overflow, underflow, inexact} !== eo)) begin
                fails++;
                $display("FAIL b2b[%0d]: valid=%b out=%h flags=%b%b%b, want valid=%b out/flags=%h",
                         i, out_valid, out, overflow, underflow, inexact, ev, eo);
            end
            if (i < 4) begin
                enable = 1'b1; sign = v[i].s; sum_2 = v[i].sum; exponent_2 = v[i].ex;
            end else begin
                enable = 1'b0;
            end
        end
    endtask

    task automatic test_reset_inflight();
        logic seen;
        @(negedge clk);
        enable = 1'b1; sign = 1'b0; sum_2 = 56'h40_0000_0000_0000; exponent_2 = 8'd127;
        @(negedge clk);
        sum_2 = 56'h80_0000_0000_0000;
        @(negedge clk);
        enable = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if ({out_valid, out, overflow, underflow, inexact} !== 36'd0) begin
            fails++;
            $display("FAIL rst_inflight_clear: valid=%b out=%h flags=%b%b%b, want all 0",
                     out_valid, out, overflow, underflow, inexact);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || out !== 32'h0) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL rst_inflight_drop: stale result after release, got seen=%b want 0", seen);
        end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; enable = 1'b0; sign = 1'b0;
        sum_2 = '0; exponent_2 = '0;
        tests = 0; fails = 0;
        test_reset();
        test_basic();
        test_carry();
        test_lzc();
        test_rne();
        test_overflow_special();
        test_back_to_back();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
